// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and the F/D latch.
// A redirect flushes F/D to a bubble. A stall freezes the PC and F/D together.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'd0,
  parameter int          IMEM_ADDR_WIDTH = 12,
  parameter logic [31:0] NOP_INSN        = 32'h00000000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_target,
  output logic [IMEM_ADDR_WIDTH-1:0] address_imem,
  input  logic [31:0]                q_imem,
  output logic [31:0]                pc_out,
  output logic [31:0]                pc_in,
  output logic [31:0]                insn_fd,
  output logic [31:0]                pc_plus1_fd,
  output logic                       valid_fd,
  output logic [31:0]                fetch_count
);

  logic [31:0] pc_plus1;
  logic        advance;

  // PC arithmetic is word-addressed and wraps modulo 2^32.
  assign pc_plus1     = pc_out + 32'd1;
  assign address_imem = pc_out[IMEM_ADDR_WIDTH-1:0];
  assign advance      = !reset && !redirect_valid && !stall;

  always_comb begin
    pc_in = pc_plus1;
    if (reset)               pc_in = RESET_PC;
    else if (redirect_valid) pc_in = redirect_target;
    else if (stall)          pc_in = pc_out;
  end

  always_ff @(posedge clock) begin
    pc_out <= pc_in;
  end

  // The stall check comes after the redirect check. A redirect therefore still
  // flushes F/D when stall is also asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      insn_fd     <= NOP_INSN;
      pc_plus1_fd <= 32'd0;
      valid_fd    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      insn_fd     <= NOP_INSN;
      pc_plus1_fd <= 32'd0;
      valid_fd    <= 1'b0;
    end else if (advance) begin
      insn_fd     <= q_imem;
      pc_plus1_fd <= pc_plus1;
      valid_fd    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run.
// Each cycle the outputs are compared with a cycle-level behavioural model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] RPC = 32'd0;

  logic        clock = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target, q_imem, pc_out, pc_in, insn_fd, pc_plus1_fd, fetch_count;
  logic [11:0] address_imem;
  logic        valid_fd;

  logic [31:0] imem [0:4095];
  assign q_imem = imem[address_imem];

  fetch_stage #(.RESET_PC(RPC), .IMEM_ADDR_WIDTH(12), .NOP_INSN(NOP)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .address_imem(address_imem), .q_imem(q_imem),
    .pc_out(pc_out), .pc_in(pc_in), .insn_fd(insn_fd), .pc_plus1_fd(pc_plus1_fd),
    .valid_fd(valid_fd), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  int checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else passes++;
  endtask

  // Reference state: the architectural view of the stage.
  logic [31:0] m_pc, m_insn, m_pc1, m_cnt;
  logic        m_v;
  bit          m_known = 0;

  // Applies one cycle of inputs. It checks the combinational outputs, then
  // clocks once and checks every registered output against the model.
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    logic [31:0] nxt;
    reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
    #1;
    nxt = rst ? RPC : rv ? tgt : st ? m_pc : m_pc + 32'd1;
    chk("pc_in", pc_in, nxt);
    if (m_known) chk("address_imem", {20'd0, address_imem}, {20'd0, m_pc[11:0]});
    @(posedge clock);
    if (rst) begin
      m_insn = NOP; m_pc1 = 0; m_v = 0; m_cnt = 0;
    end else if (rv) begin
      m_insn = NOP; m_pc1 = 0; m_v = 0;
    end else if (!st) begin
      m_insn = imem[m_pc[11:0]]; m_pc1 = m_pc + 32'd1; m_v = 1; m_cnt = m_cnt + 32'd1;
    end
    m_pc = nxt;
    m_known = 1;
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("insn_fd", insn_fd, m_insn);
    chk("pc_plus1_fd", pc_plus1_fd, m_pc1);
    chk("valid_fd", {31'd0, valid_fd}, {31'd0, m_v});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    logic [31:0] cnt_before;
    for (int i = 0; i < 4096; i++) imem[i] = $urandom;
    imem[0] = 32'hA; imem[1] = 32'hB; imem[2] = 32'hC; imem[3] = 32'hD;
    reset = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    @(posedge clock); #1;

    // 1: reset, then straight-line fetch.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("rst_pc", pc_out, RPC); chk("rst_insn", insn_fd, NOP);
    chk("rst_valid", {31'd0, valid_fd}, 32'd0); chk("rst_cnt", fetch_count, 32'd0);
    step(0, 0, 0, 0); chk("t1_insnA", insn_fd, 32'hA); chk("t1_pc1", pc_plus1_fd, 32'd1);
    step(0, 0, 0, 0); chk("t1_insnB", insn_fd, 32'hB); chk("t1_pc2", pc_out, 32'd2);

    // 2: a three-cycle stall holds the PC and F/D.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("t2_pc_hold", pc_out, 32'd2); chk("t2_insn_hold", insn_fd, 32'hB);
      chk("t2_valid_hold", {31'd0, valid_fd}, 32'd1); chk("t2_cnt_hold", fetch_count, 32'd2);
    end
    step(0, 0, 0, 0); chk("t2_insnC", insn_fd, 32'hC); chk("t2_cnt3", fetch_count, 32'd3);

    // 3: a redirect at pc_out=5 inserts one bubble.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("t3_pc5", pc_out, 32'd5);
    step(0, 0, 1, 32'd40);
    chk("t3_pc40", pc_out, 32'd40); chk("t3_bubble", insn_fd, NOP);
    chk("t3_bubble_v", {31'd0, valid_fd}, 32'd0);
    step(0, 0, 0, 0);
    chk("t3_tgt_insn", insn_fd, imem[40]); chk("t3_tgt_pc1", pc_plus1_fd, 32'd41);
    chk("t3_tgt_v", {31'd0, valid_fd}, 32'd1);

    // 4: a redirect together with a stall takes the redirect.
    cnt_before = fetch_count;
    step(0, 1, 1, 32'd8);
    chk("t4_pc8", pc_out, 32'd8); chk("t4_flush_v", {31'd0, valid_fd}, 32'd0);
    chk("t4_cnt", fetch_count, cnt_before);

    // 5: the PC wraps from FFFFFFFF to 0.
    step(0, 0, 1, 32'hFFFFFFFF);
    chk("t5_addr_fff", {20'd0, address_imem}, 32'h00000FFF);
    step(0, 0, 0, 0);
    chk("t5_pc_wrap", pc_out, 32'd0); chk("t5_pc1_wrap", pc_plus1_fd, 32'd0);
    chk("t5_addr_000", {20'd0, address_imem}, 32'd0); chk("t5_insn", insn_fd, imem[12'hFFF]);

    // 6: a reset during an active stall restores the reset values.
    step(0, 0, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t6_pc", pc_out, RPC); chk("t6_valid", {31'd0, valid_fd}, 32'd0);
    chk("t6_insn", insn_fd, NOP); chk("t6_cnt", fetch_count, 32'd0);
    step(0, 0, 0, 0); chk("t6_resume", insn_fd, 32'hA);

    // Randomized traffic; some targets land near the wrap point.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] t;
      r = $urandom_range(99);
      t = ($urandom_range(3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(3))) : $urandom;
      step(r < 2, $urandom_range(99) < 25, $urandom_range(99) < 10, t);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: owns the PC register, drives the instruction-memory address, and contains the F/D pipeline latch that feeds the decode stage.
- Accepts a stall from the data-hazard controller and a redirect (branch/jump target) from the execute stage.
- Inserts a bubble into F/D on redirect.
- Exposes PC and F/D contents so the processor testbench can probe them.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- IMEM_ADDR_WIDTH, 12, width of the instruction-memory address.
- NOP_INSN, 32'h00000000, instruction word placed in F/D when it is flushed.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and F/D contents (data hazard).
- redirect_valid  input  1  execute stage resolved a taken branch/jump this cycle.
- redirect_target  input  32  next PC when redirect_valid=1.
- address_imem  output  IMEM_ADDR_WIDTH  instruction-memory address, equal to pc_out[IMEM_ADDR_WIDTH-1:0].
- q_imem  input  32  instruction word. Combinational read: valid in the same cycle address_imem is presented.
- pc_out  output  32  current PC register value.
- pc_in  output  32  next-PC value, combinational.
- insn_fd  output  32  F/D latch instruction.
- pc_plus1_fd  output  32  F/D latch PC+1 of the latched instruction.
- valid_fd  output  1  F/D latch holds a real (non-bubble) instruction.
- fetch_count  output  32  number of instructions accepted into F/D since reset.

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - pc_out = RESET_PC
  - insn_fd = NOP_INSN
  - pc_plus1_fd = 0
  - valid_fd = 0
  - fetch_count = 0
- Priority each cycle: reset > redirect_valid > stall > normal advance.
- pc_in (combinational), by priority:
  - reset=1: RESET_PC.
  - redirect_valid=1: redirect_target.
  - stall=1: pc_out.
  - otherwise: pc_out+1.
  - The PC register loads pc_in every edge.
- PC arithmetic:
  - 32-bit unsigned, word-addressed; 32'hFFFFFFFF+1 wraps to 0.
  - address_imem takes the low bits only, so fetches alias every 2^IMEM_ADDR_WIDTH words. No error is flagged.
- F/D latch update on each edge:
  - reset: reset values above.
  - redirect_valid=1 (stall ignored): flush. insn_fd<=NOP_INSN, pc_plus1_fd<=0, valid_fd<=0. The wrong-path word currently on q_imem is discarded.
  - stall=1, no redirect: insn_fd, pc_plus1_fd and valid_fd hold their values.
  - normal: insn_fd<=q_imem, pc_plus1_fd<=pc_out+1, valid_fd<=1.
- Latency: the instruction at PC p appears on insn_fd one edge after pc_out=p, unless stalled or redirected.
- Redirect timing:
  - The target instruction enters F/D two edges after redirect_valid is sampled (one bubble).
  - Flushing the instruction already in D (squashing into D/X) belongs to the D/X latch, not this block.
- fetch_count:
  - Increments by 1 on every normal-advance edge, i.e. whenever valid_fd is written to 1.
  - Unchanged on stall, redirect and bubble cycles.
  - Wraps modulo 2^32.
- Simultaneous events:
  - stall and redirect_valid together: the redirect is taken and the stall is ignored for that cycle.
  - A stall asserted for many consecutive cycles holds state indefinitely.
  - Reset asserted mid-stream (including during stall or redirect) restores all reset values on that edge.
- The block must not itself create combinational loops with stall. stall depends only on F/D, D/X and X/M contents, never on pc_in.

Test Plan:
1. Reset held 2 cycles, then released with stall=0, redirect_valid=0, imem[0..3]=A,B,C,D → pc_out 0,1,2,3; insn_fd A,B,C on consecutive edges with pc_plus1_fd 1,2,3; fetch_count=3 after third edge.
2. stall=1 for 3 cycles while pc_out=2 and insn_fd=B → pc_out stays 2, insn_fd stays B, valid_fd stays 1, fetch_count unchanged. After release, C enters on the next edge.
3. redirect_valid=1 with redirect_target=40 while pc_out=5 → next edge: pc_out=40, insn_fd=NOP_INSN, valid_fd=0. Following edge: insn_fd=imem[40], pc_plus1_fd=41, valid_fd=1.
4. stall=1 and redirect_valid=1 (target=8) in the same cycle → redirect wins: pc_out=8, F/D flushed, fetch_count unchanged.
5. Force pc_out=32'hFFFFFFFF via redirect, no stall → next pc_out=0; address_imem=12'hFFF then 12'h000; pc_plus1_fd=0 for the word fetched at FFFFFFFF.
6. reset asserted for 1 cycle during an active stall with valid_fd=1 → pc_out=RESET_PC, valid_fd=0, insn_fd=NOP_INSN, fetch_count=0 on that edge. Fetch resumes from RESET_PC next.
